// File: rtl/bench_sig_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : bench_sig_analyzer
// Purpose : LFSR pattern source and MISR compactor for combinational benchmarks
// Revision: 1.0
// ============================================================================
module bench_sig_analyzer #(
  parameter int N_IN  = 27,
  parameter int N_OUT = 29,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [N_IN-1:0]  seed,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [N_OUT-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_pat == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)                 state_d = S_IDLE;
        else if (cnt_inc == num_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    sig_d = sig_q;
    cnt_d = cnt_q;
    num_d = num_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sig_d = '0;
          cnt_d = '0;
          if (num_pat != '0) begin
            // An all-zero seed would lock the LFSR, so substitute all ones
            x_d   = (seed == '0) ? {N_IN{1'b1}} : seed;
            num_d = num_pat;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          x_d   = '0;
          sig_d = '0;
          cnt_d = '0;
        end else begin
          sig_d = {sig_q[N_OUT-2:0], sig_q[N_OUT-1] ^ sig_q[N_OUT-3]} ^ f;
          x_d   = {x_q[N_IN-2:0], x_q[N_IN-1] ^ x_q[4] ^ x_q[1] ^ x_q[0]};
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign x         = x_q;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bench_sig_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bench_sig_analyzer
// Purpose : Scoreboard bench for bench_sig_analyzer with a toy benchmark model
// Revision: 1.0
// ============================================================================
module tb_bench_sig_analyzer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_pat;
  logic [26:0] seed;
  logic [26:0] x;
  logic [28:0] f;
  logic        busy;
  logic        done;
  logic [28:0] signature;
  logic [15:0] pat_cnt;
  int          fmode;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [28:0] sig;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [26:0] xq[$];

  bench_sig_analyzer #(.N_IN(27), .N_OUT(29), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_pat(num_pat), .seed(seed), .x(x), .f(f), .busy(busy),
    .done(done), .signature(signature), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in benchmark: mode 0 zeros, 1 ones, 2 toy logic, 3 toy logic with f8 stuck-at-1
  function automatic logic [28:0] bench_f(input logic [26:0] xv, input int mode);
    logic [28:0] r;
    r = {2'b00, xv} ^ {xv, 2'b00} ^ {29{xv[3] & xv[9]}};
    case (mode)
      0:       return '0;
      1:       return {29{1'b1}};
      3:       return r | 29'h80;
      default: return r;
    endcase
  endfunction

  always_comb f = bench_f(x, fmode);

  function automatic logic [28:0] model_sig(input logic [26:0] sd, input int n, input int mode);
    logic [26:0] xv;
    logic [28:0] s;
    xv = (sd == '0) ? {27{1'b1}} : sd;
    s  = '0;
    for (int i = 0; i < n; i++) begin
      s  = {s[27:0], s[28] ^ s[26]} ^ bench_f(xv, mode);
      xv = {xv[25:0], xv[26] ^ xv[4] ^ xv[1] ^ xv[0]};
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each done pulse and each RUN-cycle x against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && xq.size() > 0) chk("x_seq", {5'd0, x}, {5'd0, xq.pop_front()});
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_sig", {3'd0, signature}, {3'd0, e.sig});
          chk("done_cnt", {16'd0, pat_cnt}, {16'd0, e.cnt});
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called just after a negedge; returns one cycle after the start edge.
  task automatic launch(input logic [26:0] sd, input int n, input bit expect_done,
                        input logic [28:0] esig);
    if (expect_done) begin
      exp_t e;
      e.sig = esig;
      e.cnt = n[15:0];
      e.cyc = cyc + 1 + n;
      sbq.push_back(e);
    end
    seed    = sd;
    num_pat = n[15:0];
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < n + 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"},    {5'd0, x}, 32'd0);
    chk({tag, "_sig"},  {3'd0, signature}, 32'd0);
    chk({tag, "_cnt"},  {16'd0, pat_cnt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_pat = '0; seed = '0; fmode = 0;
    #3;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LFSR stepping with f tied low
    xq.push_back(27'h1); xq.push_back(27'h3); xq.push_back(27'h6); xq.push_back(27'hD);
    launch(27'h1, 4, 1'b1, 29'h0);
    wait_done(4);

    // MISR arithmetic with f tied high
    fmode = 1;
    launch(27'h1, 2, 1'b1, 29'h1);
    @(negedge clk);
    chk("misr_first_edge", {3'd0, signature}, 32'h1FFFFFFF);
    wait_done(2);

    // Zero seed substitutes all ones
    fmode = 0;
    xq.push_back(27'h7FFFFFF);
    launch(27'h0, 1, 1'b1, 29'h0);
    wait_done(1);

    // Zero count: immediate done, no busy, signature cleared from the previous 0x1
    fmode = 1;
    launch(27'h5, 2, 1'b1, 29'h1);
    wait_done(2);
    launch(27'h5, 0, 1'b1, 29'h0);
    chk("zero_cnt_busy", {31'd0, busy}, 32'd0);
    wait_done(0);

    // Abort with an ignored start inside RUN
    fmode = 2;
    launch(27'h2468ACE, 100, 1'b0, 29'h0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_cnt", {16'd0, pat_cnt}, 32'd19);
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_reset_vals("abort");
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-run, then an identical fresh run
    launch(27'h123457, 50, 1'b0, 29'h0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(27'h123457, 50, 1'b1, model_sig(27'h123457, 50, 2));
    wait_done(50);

    // Golden run and stuck-at f8 run
    launch(27'h5A5A5A5, 10000, 1'b1, model_sig(27'h5A5A5A5, 10000, 2));
    wait_done(10000);
    fmode = 3;
    launch(27'h5A5A5A5, 10000, 1'b1, model_sig(27'h5A5A5A5, 10000, 3));
    wait_done(10000);

    chk("xq_drained", xq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
